// File: rtl/cvxif_core_agent.sv
// Core-side CV-X-IF agent: accepts one offloaded instruction at a time, drives it through
// issue/register (non-split) and commit, tracks ids awaiting results, and forwards results to the
// core register-file writeback port.
module cvxif_core_agent #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NrRgprPorts = 2,
    parameter int unsigned IdWidth     = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        off_valid_i,
    output logic                        off_ready_o,
    input  logic [31:0]                 off_instr_i,
    input  logic [NrRgprPorts*XLEN-1:0] off_rs_i,
    input  logic                        off_flush_i,
    output logic                        dec_done_o,
    output logic                        dec_accept_o,
    output logic                        dec_writeback_o,
    output logic [IdWidth-1:0]          dec_id_o,
    output logic                        x_issue_valid_o,
    input  logic                        x_issue_ready_i,
    output logic [31:0]                 x_issue_instr_o,
    output logic [IdWidth-1:0]          x_issue_id_o,
    input  logic                        x_issue_accept_i,
    input  logic                        x_issue_writeback_i,
    output logic                        x_register_valid_o,
    output logic [NrRgprPorts*XLEN-1:0] x_register_rs_o,
    output logic [NrRgprPorts-1:0]      x_register_rs_valid_o,
    output logic                        x_commit_valid_o,
    output logic [IdWidth-1:0]          x_commit_id_o,
    output logic                        x_commit_kill_o,
    input  logic                        x_result_valid_i,
    output logic                        x_result_ready_o,
    input  logic [IdWidth-1:0]          x_result_id_i,
    input  logic [XLEN-1:0]             x_result_data_i,
    input  logic [4:0]                  x_result_rd_i,
    input  logic                        x_result_we_i,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic [IdWidth-1:0]          wb_id_o,
    output logic [4:0]                  wb_rd_o,
    output logic [XLEN-1:0]             wb_data_o,
    output logic                        wb_we_o,
    output logic                        err_id_o
);

    localparam int unsigned NumIds = 1 << IdWidth;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCommit
    } state_e;

    state_e                        r_state;
    state_e                        w_state_next;

    logic [IdWidth-1:0]            r_next_id;
    logic [NumIds-1:0]             r_outstanding;
    logic [NumIds-1:0]             w_outstanding_next;
    logic                          r_flush_pending;
    logic [31:0]                   r_instr;
    logic [NrRgprPorts*XLEN-1:0]   r_rs;
    logic [IdWidth-1:0]            r_id;
    logic                          r_accept;
    logic                          r_writeback;

    logic                          r_wb_valid;
    logic [IdWidth-1:0]            r_wb_id;
    logic [4:0]                    r_wb_rd;
    logic [XLEN-1:0]               r_wb_data;
    logic                          r_wb_we;
    logic                          r_err_id;

    logic                          w_off_ready;
    logic                          w_issue;
    logic                          w_commit;
    logic                          w_off_fire;
    logic                          w_issue_fire;
    logic                          w_kill;
    logic                          w_commit_set;
    logic                          w_commit_drop;
    logic                          w_res_ready;
    logic                          w_res_fire;
    logic                          w_res_same_id;
    logic                          w_res_hit;

    // State register; reset abandons any instruction in flight without committing it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and phase decode.
    always_comb begin
        w_state_next = r_state;
        w_off_ready  = 1'b0;
        w_issue      = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            StIdle: begin
                // The id about to be handed out must not still be waiting for a result.
                w_off_ready = !r_outstanding[r_next_id];
                if (off_valid_i && w_off_ready) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                w_issue = 1'b1;
                if (x_issue_ready_i) begin
                    w_state_next = StCommit;
                end
            end
            StCommit: begin
                w_commit     = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_off_fire   = off_valid_i & w_off_ready;
    assign w_issue_fire = w_issue & x_issue_ready_i;

    // A late flush during the commit cycle still kills the instruction.
    assign w_kill        = !r_accept | r_flush_pending | off_flush_i;
    assign w_commit_set  = w_commit & r_accept & r_writeback & !w_kill;
    assign w_commit_drop = w_commit & w_kill;

    assign w_res_ready   = !r_wb_valid | wb_ready_i;
    assign w_res_fire    = x_result_valid_i & w_res_ready;
    assign w_res_same_id = (x_result_id_i == r_id);
    assign w_res_hit     = r_outstanding[x_result_id_i] | (w_commit_set & w_res_same_id);

    // Instruction capture, issue response and id allocation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_next_id       <= '0;
            r_flush_pending <= 1'b0;
            r_instr         <= '0;
            r_rs            <= '0;
            r_id            <= '0;
            r_accept        <= 1'b0;
            r_writeback     <= 1'b0;
        end else begin
            if (w_off_fire) begin
                r_instr         <= off_instr_i;
                r_rs            <= off_rs_i;
                r_id            <= r_next_id;
                r_flush_pending <= 1'b0;
            end else if (w_issue && off_flush_i) begin
                r_flush_pending <= 1'b1;
            end
            if (w_issue_fire) begin
                r_accept    <= x_issue_accept_i;
                r_writeback <= x_issue_writeback_i;
                r_next_id   <= r_next_id + IdWidth'(1);
            end
        end
    end

    // Outstanding bitmap: a result taken in the same cycle as its commit never sets the bit.
    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_res_fire && r_outstanding[x_result_id_i]) begin
            w_outstanding_next[x_result_id_i] = 1'b0;
        end
        if (w_commit_set && !(w_res_fire && w_res_same_id)) begin
            w_outstanding_next[r_id] = 1'b1;
        end
    end

    // Outstanding bitmap register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
        end
    end

    // Writeback buffer and unexpected-id error pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wb_valid <= 1'b0;
            r_wb_id    <= '0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_we    <= 1'b0;
            r_err_id   <= 1'b0;
        end else begin
            r_err_id <= w_res_fire & !w_res_hit & !(w_commit_drop & w_res_same_id);
            if (w_res_fire && w_res_hit) begin
                r_wb_valid <= 1'b1;
                r_wb_id    <= x_result_id_i;
                r_wb_rd    <= x_result_rd_i;
                r_wb_data  <= x_result_data_i;
                r_wb_we    <= x_result_we_i;
            end else if (wb_ready_i) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    assign off_ready_o           = w_off_ready;
    assign x_issue_valid_o       = w_issue;
    assign x_issue_instr_o       = r_instr;
    assign x_issue_id_o          = r_id;
    assign x_register_valid_o    = w_issue;
    assign x_register_rs_o       = r_rs;
    assign x_register_rs_valid_o = {NrRgprPorts{w_issue}};
    assign x_commit_valid_o      = w_commit;
    assign x_commit_id_o         = r_id;
    assign x_commit_kill_o       = w_commit_drop;
    assign dec_done_o            = w_commit;
    assign dec_accept_o          = w_commit & r_accept & !w_kill;
    assign dec_writeback_o       = w_commit & r_writeback & !w_kill;
    assign dec_id_o              = r_id;
    assign x_result_ready_o      = w_res_ready;
    assign wb_valid_o            = r_wb_valid;
    assign wb_id_o               = r_wb_id;
    assign wb_rd_o               = r_wb_rd;
    assign wb_data_o             = r_wb_data;
    assign wb_we_o               = r_wb_we;
    assign err_id_o              = r_err_id;

endmodule

// File: tb/tb_cvxif_core_agent.sv
// Testbench for cvxif_core_agent: scenario tasks with inline checks plus a writeback scoreboard.
module tb_cvxif_core_agent;

    localparam int XLEN = 32;
    localparam int NR   = 2;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_ni;
    logic                 off_valid, off_ready_o, off_flush;
    logic [31:0]          off_instr;
    logic [NR*XLEN-1:0]   off_rs;
    logic                 dec_done_o, dec_accept_o, dec_writeback_o;
    logic [IDW-1:0]       dec_id_o;
    logic                 x_issue_valid_o, x_issue_ready, x_issue_accept, x_issue_wb;
    logic [31:0]          x_issue_instr_o;
    logic [IDW-1:0]       x_issue_id_o;
    logic                 x_register_valid_o;
    logic [NR*XLEN-1:0]   x_register_rs_o;
    logic [NR-1:0]        x_register_rs_valid_o;
    logic                 x_commit_valid_o, x_commit_kill_o;
    logic [IDW-1:0]       x_commit_id_o;
    logic                 x_result_valid, x_result_ready_o, x_result_we;
    logic [IDW-1:0]       x_result_id;
    logic [XLEN-1:0]      x_result_data;
    logic [4:0]           x_result_rd;
    logic                 wb_valid_o, wb_ready, wb_we_o;
    logic [IDW-1:0]       wb_id_o;
    logic [4:0]           wb_rd_o;
    logic [XLEN-1:0]      wb_data_o;
    logic                 err_id_o;

    cvxif_core_agent #(
        .XLEN        (XLEN),
        .NrRgprPorts (NR),
        .IdWidth     (IDW)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .off_valid_i           (off_valid),
        .off_ready_o           (off_ready_o),
        .off_instr_i           (off_instr),
        .off_rs_i              (off_rs),
        .off_flush_i           (off_flush),
        .dec_done_o            (dec_done_o),
        .dec_accept_o          (dec_accept_o),
        .dec_writeback_o       (dec_writeback_o),
        .dec_id_o              (dec_id_o),
        .x_issue_valid_o       (x_issue_valid_o),
        .x_issue_ready_i       (x_issue_ready),
        .x_issue_instr_o       (x_issue_instr_o),
        .x_issue_id_o          (x_issue_id_o),
        .x_issue_accept_i      (x_issue_accept),
        .x_issue_writeback_i   (x_issue_wb),
        .x_register_valid_o    (x_register_valid_o),
        .x_register_rs_o       (x_register_rs_o),
        .x_register_rs_valid_o (x_register_rs_valid_o),
        .x_commit_valid_o      (x_commit_valid_o),
        .x_commit_id_o         (x_commit_id_o),
        .x_commit_kill_o       (x_commit_kill_o),
        .x_result_valid_i      (x_result_valid),
        .x_result_ready_o      (x_result_ready_o),
        .x_result_id_i         (x_result_id),
        .x_result_data_i       (x_result_data),
        .x_result_rd_i         (x_result_rd),
        .x_result_we_i         (x_result_we),
        .wb_valid_o            (wb_valid_o),
        .wb_ready_i            (wb_ready),
        .wb_id_o               (wb_id_o),
        .wb_rd_o               (wb_rd_o),
        .wb_data_o             (wb_data_o),
        .wb_we_o               (wb_we_o),
        .err_id_o              (err_id_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            we;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_exp;
    wb_t mon_got;

    // Observations captured by run_instr for the calling test to judge.
    int                 obs_held;
    logic [IDW-1:0]     obs_id;
    logic [31:0]        obs_instr;
    logic [NR*XLEN-1:0] obs_rs;
    logic [NR-1:0]      obs_rsv;
    logic               obs_cval, obs_ckill, obs_dacc, obs_dwb, obs_ddone;
    logic [IDW-1:0]     obs_cid, obs_did;

    // Scoreboard: every writeback handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_ni && wb_valid_o && wb_ready) begin
            n_cmp++;
            mon_got = wb_t'{wb_id_o, wb_rd_o, wb_data_o, wb_we_o};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got %h, required no writeback", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL wb_payload: got %h, required %h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic idle_inputs();
        off_valid = 0; off_instr = '0; off_rs = '0; off_flush = 0;
        x_issue_ready = 0; x_issue_accept = 0; x_issue_wb = 0;
        x_result_valid = 0; x_result_id = '0; x_result_data = '0; x_result_rd = '0;
        x_result_we = 0; wb_ready = 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_ni = 0;
        idle_inputs();
        @(posedge clk); #1;
        rst_ni = 1;
    endtask

    // Offload one instruction; issue handshake after `delay` ISSUE cycles; ends at commit negedge.
    task automatic run_instr(input logic [31:0] instr, input logic [NR*XLEN-1:0] rs,
                             input int delay, input logic acc, input logic wbk, input logic flush);
        @(posedge clk); #1;
        off_valid = 1; off_instr = instr; off_rs = rs;
        @(negedge clk);
        if (!off_ready_o) begin
            n_cmp++; n_err++;
            $display("FAIL offload_ready: got 0, required 1");
        end
        @(posedge clk); #1;
        off_valid = 0; off_instr = '0; off_rs = '0;
        obs_held = 0;
        for (int c = 0; c <= delay; c++) begin
            off_flush = flush && (c == 0);
            if (c == delay) begin
                x_issue_ready = 1; x_issue_accept = acc; x_issue_wb = wbk;
            end
            @(negedge clk);
            if (x_issue_valid_o) obs_held++;
            obs_id = x_issue_id_o; obs_instr = x_issue_instr_o;
            obs_rs = x_register_rs_o; obs_rsv = x_register_rs_valid_o;
            @(posedge clk); #1;
        end
        x_issue_ready = 0; x_issue_accept = 0; x_issue_wb = 0; off_flush = 0;
        @(negedge clk);
        obs_cval = x_commit_valid_o; obs_ckill = x_commit_kill_o; obs_cid = x_commit_id_o;
        obs_dacc = dec_accept_o; obs_dwb = dec_writeback_o; obs_ddone = dec_done_o;
        obs_did = dec_id_o;
    endtask

    // Present a result until it is taken (bounded); ends at posedge+1 after the handshake.
    task automatic send_result(input logic [IDW-1:0] id, input logic [XLEN-1:0] data,
                               input logic [4:0] rd, input logic we, input logic expect_wb);
        bit got = 0;
        @(posedge clk); #1;
        x_result_valid = 1; x_result_id = id; x_result_data = data;
        x_result_rd = rd; x_result_we = we;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (x_result_ready_o) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL result_timeout: got ready=0 for 50 cycles, required ready=1");
        end else if (expect_wb) begin
            exp_q.push_back(wb_t'{id, rd, data, we});
        end
        @(posedge clk); #1;
        x_result_valid = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({x_issue_valid_o, x_register_valid_o, x_commit_valid_o, x_commit_kill_o,
             dec_done_o, err_id_o, wb_valid_o} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b, required 0000000",
                     {x_issue_valid_o, x_register_valid_o, x_commit_valid_o, x_commit_kill_o,
                      dec_done_o, err_id_o, wb_valid_o});
        end
        n_cmp++;
        if ({wb_data_o, x_issue_instr_o, x_register_rs_valid_o} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got wb_data=%h instr=%h rsv=%b, required 0",
                     wb_data_o, x_issue_instr_o, x_register_rs_valid_o);
        end
        @(posedge clk); #1;
        rst_ni = 1;
        @(negedge clk);
        n_cmp++;
        if (off_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_off_ready: got %b, required 1", off_ready_o);
        end
    endtask

    task automatic test_basic();
        run_instr(32'h0000_002B, {32'd7, 32'd5}, 2, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs_held !== 3) begin
            n_err++; $display("FAIL basic_issue_held: got %0d, required 3", obs_held);
        end
        n_cmp++;
        if ({obs_id, obs_instr, obs_rs, obs_rsv} !== {2'd0, 32'h2B, 32'd7, 32'd5, 2'b11}) begin
            n_err++;
            $display("FAIL basic_issue_payload: got id=%0d instr=%h rs=%h rsv=%b, required 0 2b 7/5 11",
                     obs_id, obs_instr, obs_rs, obs_rsv);
        end
        n_cmp++;
        if ({obs_cval, obs_ckill, obs_ddone, obs_dacc, obs_dwb, obs_cid, obs_did}
                !== {5'b10111, 2'd0, 2'd0}) begin
            n_err++;
            $display("FAIL basic_commit: got val/kill/done/acc/wb=%b%b%b%b%b id=%0d/%0d, required 10111 0/0",
                     obs_cval, obs_ckill, obs_ddone, obs_dacc, obs_dwb, obs_cid, obs_did);
        end
        send_result(2'd0, 32'd12, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({wb_valid_o, wb_data_o, wb_rd_o} !== {1'b1, 32'd12, 5'd3}) begin
            n_err++;
            $display("FAIL basic_wb: got valid=%b data=%0d rd=%0d, required 1 12 3",
                     wb_valid_o, wb_data_o, wb_rd_o);
        end
    endtask

    task automatic test_reject();
        do_reset();
        run_instr(32'h0000_005B, {32'd1, 32'd2}, 0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({obs_id, obs_ckill, obs_dacc, obs_dwb} !== {2'd0, 3'b100}) begin
            n_err++;
            $display("FAIL reject_commit: got id=%0d kill=%b acc=%b wb=%b, required 0 1 0 0",
                     obs_id, obs_ckill, obs_dacc, obs_dwb);
        end
        send_result(2'd0, 32'h55, 5'd4, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({err_id_o, wb_valid_o} !== 2'b10) begin
            n_err++;
            $display("FAIL reject_not_outstanding: got err=%b wbv=%b, required 1 0",
                     err_id_o, wb_valid_o);
        end
        run_instr(32'h0000_007B, {32'd3, 32'd4}, 1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({obs_id, obs_ckill, obs_dacc, obs_dwb} !== {2'd1, 3'b010}) begin
            n_err++;
            $display("FAIL reject_next_id: got id=%0d kill=%b acc=%b wb=%b, required 1 0 1 0",
                     obs_id, obs_ckill, obs_dacc, obs_dwb);
        end
    endtask

    task automatic test_flush();
        do_reset();
        run_instr(32'h0000_102B, {32'd9, 32'd8}, 2, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if ({obs_held, obs_cval, obs_ckill, obs_dacc, obs_dwb} !== {32'd3, 4'b1100}) begin
            n_err++;
            $display("FAIL flush_commit: got held=%0d val=%b kill=%b acc=%b wb=%b, required 3 1 1 0 0",
                     obs_held, obs_cval, obs_ckill, obs_dacc, obs_dwb);
        end
        send_result(2'd0, 32'h66, 5'd6, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({err_id_o, wb_valid_o} !== 2'b10) begin
            n_err++;
            $display("FAIL flush_no_outstanding: got err=%b wbv=%b, required 1 0",
                     err_id_o, wb_valid_o);
        end
    endtask

    task automatic test_wrap();
        logic [IDW-1:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            want = IDW'(i);
            run_instr(32'h0000_202B + i, {32'(i), 32'(i + 10)}, i % 2, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs_id !== want) begin
                n_err++; $display("FAIL wrap_id_%0d: got %0d, required %0d", i, obs_id, want);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (off_ready_o !== 1'b0) begin
            n_err++; $display("FAIL wrap_full_ready: got %b, required 0", off_ready_o);
        end
        send_result(2'd0, 32'h100, 5'd1, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (off_ready_o !== 1'b1) begin
            n_err++; $display("FAIL wrap_freed_ready: got %b, required 1", off_ready_o);
        end
        run_instr(32'h0000_302B, {32'd0, 32'd0}, 0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs_id !== 2'd0) begin
            n_err++; $display("FAIL wrap_reuse_id: got %0d, required 0", obs_id);
        end
        send_result(2'd3, 32'h303, 5'd13, 1'b1, 1'b1);
        send_result(2'd1, 32'h101, 5'd11, 1'b1, 1'b1);
        send_result(2'd2, 32'h202, 5'd12, 1'b0, 1'b1);
        send_result(2'd0, 32'h400, 5'd10, 1'b1, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_err_backpressure();
        do_reset();
        send_result(2'd2, 32'hBAD, 5'd2, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({err_id_o, wb_valid_o} !== 2'b10) begin
            n_err++; $display("FAIL err_pulse: got err=%b wbv=%b, required 1 0", err_id_o, wb_valid_o);
        end
        @(negedge clk);
        n_cmp++;
        if (err_id_o !== 1'b0) begin
            n_err++; $display("FAIL err_one_cycle: got %b, required 0", err_id_o);
        end
        run_instr(32'h0000_402B, {32'd1, 32'd1}, 0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        wb_ready = 0;
        send_result(2'd0, 32'hDEAD, 5'd9, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({wb_valid_o, wb_data_o, wb_rd_o, x_result_ready_o} !== {1'b1, 32'hDEAD, 5'd9, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got wbv=%b data=%h rd=%0d rready=%b, required 1 dead 9 0",
                         c, wb_valid_o, wb_data_o, wb_rd_o, x_result_ready_o);
            end
            @(posedge clk); #1;
        end
        wb_ready = 1;
        @(negedge clk);
        n_cmp++;
        if (x_result_ready_o !== 1'b1) begin
            n_err++; $display("FAIL bp_release_ready: got %b, required 1", x_result_ready_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (wb_valid_o !== 1'b0) begin
            n_err++; $display("FAIL bp_drained: got %b, required 0", wb_valid_o);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        @(posedge clk); #1;
        off_valid = 1; off_instr = 32'h0000_105B; off_rs = {32'd2, 32'd3};
        @(posedge clk); #1;
        off_valid = 0; x_issue_ready = 1; x_issue_accept = 1; x_issue_wb = 1;
        @(posedge clk); #1;
        x_issue_ready = 0; x_issue_accept = 0; x_issue_wb = 0;
        x_result_valid = 1; x_result_id = 2'd0; x_result_data = 32'hABCD;
        x_result_rd = 5'd7; x_result_we = 1;
        @(negedge clk);
        n_cmp++;
        if ({x_commit_valid_o, x_commit_kill_o, x_result_ready_o} !== 3'b101) begin
            n_err++;
            $display("FAIL same_commit: got val=%b kill=%b rready=%b, required 1 0 1",
                     x_commit_valid_o, x_commit_kill_o, x_result_ready_o);
        end
        exp_q.push_back(wb_t'{2'd0, 5'd7, 32'hABCD, 1'b1});
        @(posedge clk); #1;
        x_result_valid = 0;
        @(negedge clk);
        n_cmp++;
        if ({wb_valid_o, err_id_o, wb_data_o} !== {2'b10, 32'hABCD}) begin
            n_err++;
            $display("FAIL same_wb: got wbv=%b err=%b data=%h, required 1 0 abcd",
                     wb_valid_o, err_id_o, wb_data_o);
        end
        send_result(2'd0, 32'h1, 5'd1, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (err_id_o !== 1'b1) begin
            n_err++; $display("FAIL same_not_set: got err=%b, required 1", err_id_o);
        end
        // Killed in commit while its result arrives: dropped without error.
        @(posedge clk); #1;
        off_valid = 1; off_instr = 32'h0000_205B;
        @(posedge clk); #1;
        off_valid = 0; x_issue_ready = 1; x_issue_accept = 1; x_issue_wb = 1;
        @(posedge clk); #1;
        x_issue_ready = 0; x_issue_accept = 0; x_issue_wb = 0; off_flush = 1;
        x_result_valid = 1; x_result_id = 2'd1; x_result_data = 32'h77;
        @(negedge clk);
        n_cmp++;
        if ({x_commit_valid_o, x_commit_kill_o, dec_accept_o, x_commit_id_o} !== {3'b110, 2'd1}) begin
            n_err++;
            $display("FAIL kill_commit: got val=%b kill=%b acc=%b id=%0d, required 1 1 0 1",
                     x_commit_valid_o, x_commit_kill_o, dec_accept_o, x_commit_id_o);
        end
        @(posedge clk); #1;
        off_flush = 0; x_result_valid = 0;
        @(negedge clk);
        n_cmp++;
        if ({err_id_o, wb_valid_o} !== 2'b00) begin
            n_err++;
            $display("FAIL kill_silent_drop: got err=%b wbv=%b, required 0 0", err_id_o, wb_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_instr(32'h0000_502B, {32'd5, 32'd5}, 0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        off_valid = 1; off_instr = 32'h0000_602B;
        @(posedge clk); #1;
        off_valid = 0;
        @(negedge clk);
        n_cmp++;
        if ({x_issue_valid_o, x_issue_id_o} !== {1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL rmid_pre_issue: got val=%b id=%0d, required 1 1", x_issue_valid_o, x_issue_id_o);
        end
        @(posedge clk); #1;
        rst_ni = 0;
        @(posedge clk); #1;
        rst_ni = 1;
        @(negedge clk);
        n_cmp++;
        if ({x_issue_valid_o, x_register_valid_o, x_commit_valid_o, dec_done_o, wb_valid_o,
             off_ready_o} !== 6'b000001) begin
            n_err++;
            $display("FAIL rmid_flags: got %b, required 000001",
                     {x_issue_valid_o, x_register_valid_o, x_commit_valid_o, dec_done_o,
                      wb_valid_o, off_ready_o});
        end
        send_result(2'd0, 32'h9, 5'd9, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (err_id_o !== 1'b1) begin
            n_err++; $display("FAIL rmid_outstanding_cleared: got err=%b, required 1", err_id_o);
        end
        run_instr(32'h0000_702B, {32'd6, 32'd6}, 1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({obs_id, obs_cval, obs_ckill} !== {2'd0, 2'b10}) begin
            n_err++;
            $display("FAIL rmid_next_id: got id=%0d val=%b kill=%b, required 0 1 0",
                     obs_id, obs_cval, obs_ckill);
        end
    endtask

    initial begin
        rst_ni = 0;
        idle_inputs();
        test_reset();
        test_basic();
        test_reject();
        test_flush();
        test_wrap();
        test_err_backpressure();
        test_same_cycle();
        test_reset_mid();
        repeat (2) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
